// File: rtl/divider_pkg.sv
// ---------------------------------------------------------------------------
// divider_pkg
//   Shared types and helpers for the iterative signed/unsigned divider.
//   - div_state_e : FSM state encoding, also exported on the debug state port.
//   - cnt_width() : width of a counter that must hold 0..num_bits inclusive.
//                   Used for both the leading-zero count and the iteration
//                   counter.
// ---------------------------------------------------------------------------
package divider_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PREP     = 3'd1,
        S_SUBTRACT = 3'd2,
        S_FIXUP    = 3'd3,
        S_OUTPUT   = 3'd4
    } div_state_e;

    function automatic int cnt_width(input int num_bits);
        return $clog2(num_bits + 1);
    endfunction

endpackage

// File: rtl/lzc_count.sv
// ---------------------------------------------------------------------------
// lzc_count
//   Combinational leading-zero counter.
//   Ports:
//     data_i  [WIDTH]            value to inspect
//     count_o [cnt_width(WIDTH)] number of leading zeros; WIDTH when data_i == 0
// ---------------------------------------------------------------------------
module lzc_count
    import divider_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0]            data_i,
    output logic [cnt_width(WIDTH)-1:0] count_o
);

    localparam int CW = cnt_width(WIDTH);

    // Scan upward: the last set bit seen is the most significant one,
    // so its position decides the final count.
    always_comb begin
        count_o = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (data_i[i]) begin
                count_o = CW'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/divider_iterative_signed.sv
// ---------------------------------------------------------------------------
// divider_iterative_signed
//   Iterative restoring shift-subtract divider with per-operation signed or
//   unsigned operands. Leading zeros of |numerator| are skipped when
//   EARLY_TERM=1, so latency is k+3 edges (accept edge counted as the first),
//   k = significant bits of |numerator| (0 for a zero numerator or a zero
//   denominator).
//
//   Handshake: a transfer happens on a posedge where CE=1 and both valid and
//   ready are high. in_ready is high only in S_IDLE; out_valid is high only
//   in S_OUTPUT and the result holds there until out_ready is seen with CE=1.
//   CE=0 freezes every register, including the handshake state.
//
//   Ports:
//     CLK, SRST_N (sync, active low), CE (clock enable)
//     in_valid/in_ready, SIGNED_MODE, NUMERATOR_IN, DENOMINATOR_IN : request
//     out_valid/out_ready, QUOTIENT_OUT, REMAINDER_OUT              : result
//     div_zero  : denominator was zero (qualified by out_valid)
//     overflow  : signed MIN / -1      (qualified by out_valid)
//     dbg_state_o : current FSM state
// ---------------------------------------------------------------------------
module divider_iterative_signed
    import divider_pkg::*;
#(
    parameter int DIV_NUM_BITS = 16,
    parameter int DIV_DEN_BITS = 16,
    parameter bit EARLY_TERM   = 1'b1
) (
    input  logic                    CLK,
    input  logic                    SRST_N,
    input  logic                    CE,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    SIGNED_MODE,
    input  logic [DIV_NUM_BITS-1:0] NUMERATOR_IN,
    input  logic [DIV_DEN_BITS-1:0] DENOMINATOR_IN,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DIV_NUM_BITS-1:0] QUOTIENT_OUT,
    output logic [DIV_DEN_BITS-1:0] REMAINDER_OUT,
    output logic                    div_zero,
    output logic                    overflow,
    output div_state_e              dbg_state_o
);

    localparam int N   = DIV_NUM_BITS;
    localparam int D   = DIV_DEN_BITS;
    localparam int RQW = N + D + 1;
    localparam int CW  = cnt_width(N);

    div_state_e      state_q;
    logic [N-1:0]    num_q;
    logic [D-1:0]    den_q;
    logic            sign_q;
    logic [D-1:0]    den_mag_q;
    logic            neg_quot_q;
    logic            neg_rem_q;
    logic [RQW-1:0]  rem_quot_q;
    logic [CW-1:0]   cnt_q;
    logic [N-1:0]    quot_q;
    logic [D-1:0]    rem_q;
    logic            div_zero_q;
    logic            overflow_q;

    logic [N-1:0]    num_mag_d;
    logic [D-1:0]    den_mag_d;
    logic [CW-1:0]   lz_raw;
    logic [CW-1:0]   lz_d;
    logic [CW-1:0]   k_d;
    logic [RQW-1:0]  shifted_d;
    logic [RQW-1:0]  rem_quot_d;
    logic            den_zero_d;
    logic            overflow_d;
    logic [D-1:0]    dz_rem_d;

    lzc_count #(.WIDTH(N)) u_lzc (
        .data_i  (num_mag_d),
        .count_o (lz_raw)
    );

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_OUTPUT);
    end

    always_comb begin
        num_mag_d  = (sign_q && num_q[N-1]) ? (~num_q + 1'b1) : num_q;
        den_mag_d  = (sign_q && den_q[D-1]) ? (~den_q + 1'b1) : den_q;
        lz_d       = EARLY_TERM ? lz_raw : '0;
        k_d        = CW'(N) - lz_d;
        den_zero_d = (den_q == '0);
        overflow_d = sign_q && (num_q == {1'b1, {(N-1){1'b0}}}) && (den_q == '1);
        // Divide-by-zero remainder is the numerator resized to the remainder
        // width: sign-extended in signed mode, zero-extended otherwise.
        dz_rem_d   = sign_q ? D'($signed(num_q)) : D'(num_q);

        // One restoring step. The partial remainder lives in the upper D+1
        // bits; the extra bit keeps the compare exact when den's MSb is set.
        shifted_d = rem_quot_q << 1;
        if (shifted_d[RQW-1:N] >= {1'b0, den_mag_q}) begin
            rem_quot_d = {shifted_d[RQW-1:N] - {1'b0, den_mag_q}, shifted_d[N-1:1], 1'b1};
        end else begin
            rem_quot_d = shifted_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (!SRST_N) begin
            state_q    <= S_IDLE;
            num_q      <= '0;
            den_q      <= '0;
            sign_q     <= 1'b0;
            den_mag_q  <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            rem_quot_q <= '0;
            cnt_q      <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
            div_zero_q <= 1'b0;
            overflow_q <= 1'b0;
        end else if (CE) begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        num_q   <= NUMERATOR_IN;
                        den_q   <= DENOMINATOR_IN;
                        sign_q  <= SIGNED_MODE;
                        state_q <= S_PREP;
                    end
                end
                S_PREP: begin
                    den_mag_q  <= den_mag_d;
                    neg_quot_q <= sign_q & (num_q[N-1] ^ den_q[D-1]);
                    neg_rem_q  <= sign_q & num_q[N-1];
                    // Left-justify the magnitude so only significant bits iterate.
                    rem_quot_q <= {{(D+1){1'b0}}, num_mag_d << lz_d};
                    cnt_q      <= k_d;
                    state_q    <= (den_zero_d || (k_d == '0)) ? S_FIXUP : S_SUBTRACT;
                end
                S_SUBTRACT: begin
                    rem_quot_q <= rem_quot_d;
                    cnt_q      <= cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        state_q <= S_FIXUP;
                    end
                end
                S_FIXUP: begin
                    if (den_zero_d) begin
                        quot_q     <= '1;
                        rem_q      <= dz_rem_d;
                        div_zero_q <= 1'b1;
                        overflow_q <= 1'b0;
                    end else begin
                        // MIN / -1 falls out naturally: |MIN| negated wraps to MIN.
                        quot_q     <= neg_quot_q ? (~rem_quot_q[N-1:0] + 1'b1) : rem_quot_q[N-1:0];
                        rem_q      <= neg_rem_q ? (~rem_quot_q[N+D-1:N] + 1'b1) : rem_quot_q[N+D-1:N];
                        div_zero_q <= 1'b0;
                        overflow_q <= overflow_d;
                    end
                    state_q <= S_OUTPUT;
                end
                S_OUTPUT: begin
                    if (out_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign QUOTIENT_OUT  = quot_q;
    assign REMAINDER_OUT = rem_q;
    assign div_zero      = div_zero_q;
    assign overflow      = overflow_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_divider_iterative_signed.sv
// ---------------------------------------------------------------------------
// tb_divider_iterative_signed
//   Main instance: 16/16, EARLY_TERM=1. Auxiliary instances share one request
//   channel: 8/8 with EARLY_TERM=1 and 16/16 with EARLY_TERM=0.
//   Expected results come from integer arithmetic on the operands; expected
//   latency from the bit length of |numerator|.
// ---------------------------------------------------------------------------
module tb_divider_iterative_signed;

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    logic SRST_N;
    logic CE;
    always #5 CLK = ~CLK;

    // ---------------- main instance ----------------
    logic        in_valid, in_ready, signed_mode, out_valid, out_ready;
    logic [15:0] num_in, den_in, quotient, remainder;
    logic        div_zero, overflow;
    logic [2:0]  dbg_state;

    divider_iterative_signed #(.DIV_NUM_BITS(16), .DIV_DEN_BITS(16), .EARLY_TERM(1'b1)) dut (
        .CLK(CLK), .SRST_N(SRST_N), .CE(CE),
        .in_valid(in_valid), .in_ready(in_ready), .SIGNED_MODE(signed_mode),
        .NUMERATOR_IN(num_in), .DENOMINATOR_IN(den_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .QUOTIENT_OUT(quotient), .REMAINDER_OUT(remainder),
        .div_zero(div_zero), .overflow(overflow), .dbg_state_o(dbg_state)
    );

    // ---------------- auxiliary instances ----------------
    logic        in_valid_a, out_ready_a;
    logic [15:0] num_a, den_a;
    logic [7:0]  num_a8, den_a8;
    logic        in_ready8, out_valid8, dz8, ov8;
    logic [7:0]  q8, r8;
    logic [2:0]  st8;
    logic        in_ready_ne, out_valid_ne, dz_ne, ov_ne;
    logic [15:0] q_ne, r_ne;
    logic [2:0]  st_ne;

    divider_iterative_signed #(.DIV_NUM_BITS(8), .DIV_DEN_BITS(8), .EARLY_TERM(1'b1)) dut8 (
        .CLK(CLK), .SRST_N(SRST_N), .CE(CE),
        .in_valid(in_valid_a), .in_ready(in_ready8), .SIGNED_MODE(1'b0),
        .NUMERATOR_IN(num_a8), .DENOMINATOR_IN(den_a8),
        .out_valid(out_valid8), .out_ready(out_ready_a),
        .QUOTIENT_OUT(q8), .REMAINDER_OUT(r8),
        .div_zero(dz8), .overflow(ov8), .dbg_state_o(st8)
    );

    divider_iterative_signed #(.DIV_NUM_BITS(16), .DIV_DEN_BITS(16), .EARLY_TERM(1'b0)) dut_ne (
        .CLK(CLK), .SRST_N(SRST_N), .CE(CE),
        .in_valid(in_valid_a), .in_ready(in_ready_ne), .SIGNED_MODE(1'b0),
        .NUMERATOR_IN(num_a), .DENOMINATOR_IN(den_a),
        .out_valid(out_valid_ne), .out_ready(out_ready_a),
        .QUOTIENT_OUT(q_ne), .REMAINDER_OUT(r_ne),
        .div_zero(dz_ne), .overflow(ov_ne), .dbg_state_o(st_ne)
    );

    // ---------------- scoreboard ----------------
    // Entry layout: {div_zero, overflow, quotient[15:0], remainder[15:0]}
    logic [33:0] exp_q[$];
    int n_checks = 0;
    int n_bad    = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [33:0] ref_div(input logic sm, input logic [15:0] n, input logic [15:0] d);
        longint a, b, q, r;
        logic   dz, ov;
        a  = sm ? longint'($signed(n)) : longint'(n);
        b  = sm ? longint'($signed(d)) : longint'(d);
        dz = 1'b0;
        ov = 1'b0;
        if (b == 0) begin
            q  = -1;
            r  = a;
            dz = 1'b1;
        end else if (sm && a == -32768 && b == -1) begin
            q  = -32768;
            r  = 0;
            ov = 1'b1;
        end else begin
            q = a / b;
            r = a % b;
        end
        return {dz, ov, q[15:0], r[15:0]};
    endfunction

    // Number of significant bits of |n|.
    function automatic int ref_k(input logic sm, input logic [15:0] n);
        longint m;
        int     k;
        m = sm ? longint'($signed(n)) : longint'(n);
        if (m < 0) m = -m;
        k = 0;
        while ((m >> k) != 0) k++;
        return k;
    endfunction

    // ---------------- driver: one operation on the main instance ----------------
    // ce_gap  : CE-low cycles inserted after the second edge
    // hold    : cycles the result is held before out_ready (first one with CE=0)
    // abort_at: when nonzero, reset is applied at that point instead of finishing
    task automatic do_op(input logic sm, input logic [15:0] n, input logic [15:0] d,
                         input int ce_gap, input int hold, input int abort_at);
        logic [33:0] exp;
        int          lat;
        int          exp_lat;
        int          guard;
        longint      a, b, qs, rs;
        logic        inv_ok;
        exp_lat = ((d == 16'h0) ? 3 : ref_k(sm, n) + 3) + ce_gap;
        guard   = 0;
        while (!in_ready && guard < 50) begin
            @(negedge CLK);
            guard++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 64'(in_ready), 64'd1);
            return;
        end
        in_valid    = 1'b1;
        signed_mode = sm;
        num_in      = n;
        den_in      = d;
        @(negedge CLK);
        in_valid    = 1'b0;
        signed_mode = 1'($urandom);
        num_in      = 16'($urandom);
        den_in      = 16'($urandom);
        exp_q.push_back(ref_div(sm, n, d));
        lat = 1;
        check("in_ready_busy", 64'(in_ready), 64'd0);
        while (!out_valid && lat < exp_lat + 40) begin
            if (abort_at != 0 && lat == abort_at) begin
                SRST_N = 1'b0;
                @(negedge CLK);
                SRST_N = 1'b1;
                check("abort_in_ready", 64'(in_ready), 64'd1);
                check("abort_out_valid", 64'(out_valid), 64'd0);
                check("abort_quotient", 64'(quotient), 64'd0);
                check("abort_state", 64'(dbg_state), 64'd0);
                void'(exp_q.pop_back());
                return;
            end
            if (lat == 2 && ce_gap > 0) begin
                CE = 1'b0;
                repeat (ce_gap) begin
                    @(negedge CLK);
                    lat++;
                    check("ce_low_no_valid", 64'(out_valid), 64'd0);
                end
                CE = 1'b1;
            end else begin
                @(negedge CLK);
                lat++;
            end
        end
        exp = exp_q.pop_front();
        if (!out_valid) begin
            check("out_valid_timeout", 64'(out_valid), 64'd1);
            return;
        end
        check("latency", 64'(lat), 64'(exp_lat));
        check("quotient", 64'(quotient), 64'(exp[31:16]));
        check("remainder", 64'(remainder), 64'(exp[15:0]));
        check("div_zero", 64'(div_zero), 64'(exp[33]));
        check("overflow", 64'(overflow), 64'(exp[32]));
        if (!exp[33] && !exp[32]) begin
            a  = sm ? longint'($signed(n)) : longint'(n);
            b  = sm ? longint'($signed(d)) : longint'(d);
            qs = sm ? longint'($signed(quotient)) : longint'(quotient);
            rs = sm ? longint'($signed(remainder)) : longint'(remainder);
            inv_ok = (a == qs * b + rs) && ((rs < 0 ? -rs : rs) < (b < 0 ? -b : b));
            check("invariant", 64'(inv_ok), 64'd1);
        end
        for (int i = 0; i < hold; i++) begin
            if (i == 0) begin
                CE        = 1'b0;
                out_ready = 1'b1;
            end
            @(negedge CLK);
            CE        = 1'b1;
            out_ready = 1'b0;
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_quotient", 64'(quotient), 64'(exp[31:16]));
            check("hold_remainder", 64'(remainder), 64'(exp[15:0]));
        end
        out_ready = 1'b1;
        @(negedge CLK);
        out_ready = 1'b0;
        check("drain_out_valid", 64'(out_valid), 64'd0);
        check("drain_in_ready", 64'(in_ready), 64'd1);
    endtask

    // ---------------- driver: one unsigned op on both auxiliary instances ----------------
    task automatic aux_op(input logic [7:0] n, input logic [7:0] d);
        int lat, l8, lne, exp8, expne, eq, er;
        exp8  = (d == 8'h0) ? 3 : ref_k(1'b0, {8'h00, n}) + 3;
        expne = (d == 8'h0) ? 3 : 19;
        eq    = (d == 8'h0) ? 255 : int'(n) / int'(d);
        er    = (d == 8'h0) ? int'(n) : int'(n) % int'(d);
        num_a  = {8'h00, n};
        den_a  = {8'h00, d};
        num_a8 = n;
        den_a8 = d;
        in_valid_a = 1'b1;
        @(negedge CLK);
        in_valid_a = 1'b0;
        num_a  = 16'($urandom);
        den_a  = 16'($urandom);
        num_a8 = 8'($urandom);
        den_a8 = 8'($urandom);
        lat = 1;
        l8  = 0;
        lne = 0;
        while ((l8 == 0 || lne == 0) && lat < 60) begin
            if (out_valid8 && l8 == 0) l8 = lat;
            if (out_valid_ne && lne == 0) lne = lat;
            if (l8 == 0 || lne == 0) begin
                @(negedge CLK);
                lat++;
            end
        end
        check("aux8_latency", 64'(l8), 64'(exp8));
        check("aux8_quotient", 64'(q8), 64'(eq));
        check("aux8_remainder", 64'(r8), 64'(er));
        check("aux8_div_zero", 64'(dz8), 64'(d == 8'h0));
        check("noet_latency", 64'(lne), 64'(expne));
        check("noet_quotient", 64'(q_ne), 64'(eq));
        check("noet_remainder", 64'(r_ne), 64'(er));
        out_ready_a = 1'b1;
        @(negedge CLK);
        out_ready_a = 1'b0;
        check("aux_drain", 64'({in_ready8, in_ready_ne}), 64'd3);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic        sm;
        logic [15:0] n, d;
        int          cls;
        SRST_N      = 1'b0;
        CE          = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        signed_mode = 1'b0;
        num_in      = '0;
        den_in      = '0;
        in_valid_a  = 1'b0;
        out_ready_a = 1'b0;
        num_a       = '0;
        den_a       = '0;
        num_a8      = '0;
        den_a8      = '0;
        repeat (3) @(negedge CLK);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_outputs", 64'({quotient, remainder, div_zero, overflow}), 64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);
        SRST_N = 1'b1;
        @(negedge CLK);

        // Directed cases
        do_op(1'b1, 16'hFFF9, 16'h0002, 0, 0, 0);   // -7 / 2
        do_op(1'b1, 16'h0007, 16'hFFFE, 0, 0, 0);   //  7 / -2
        do_op(1'b1, 16'h8000, 16'hFFFF, 0, 0, 0);   // MIN / -1
        do_op(1'b0, 16'd1234, 16'h0000, 0, 0, 0);   // divide by zero
        do_op(1'b1, 16'hFB2E, 16'h0000, 0, 0, 0);   // -1234 / 0
        do_op(1'b0, 16'd1, 16'd1, 0, 0, 0);         // early termination, k=1
        do_op(1'b0, 16'd0, 16'd5, 0, 0, 0);         // zero numerator
        do_op(1'b0, 16'hFFFF, 16'h8001, 0, 0, 0);   // denominator MSb set
        do_op(1'b0, 16'd200, 16'd7, 0, 10, 0);      // backpressure hold
        do_op(1'b1, 16'hD8F1, 16'd13, 4, 0, 0);     // CE low mid-operation
        do_op(1'b0, 16'd40000, 16'd3, 0, 0, 5);     // reset while subtracting
        do_op(1'b0, 16'd100, 16'd3, 0, 0, 0);

        aux_op(8'd200, 8'd7);
        aux_op(8'd1, 8'd1);

        // Constrained-random
        for (int i = 0; i < 1500; i++) begin
            sm  = 1'($urandom_range(0, 1));
            cls = $urandom_range(0, 7);
            n   = 16'($urandom);
            d   = 16'($urandom);
            case (cls)
                0: d = 16'h0000;
                1: begin sm = 1'b1; n = 16'h8000; d = 16'hFFFF; end
                2: n = 16'($urandom_range(0, 15));
                3: d = ($urandom_range(0, 1) != 0) ? 16'h0001 : 16'hFFFF;
                4: d = 16'($urandom_range(1, 40));
                default: ;
            endcase
            do_op(sm, n, d, 0, $urandom_range(0, 2), 0);
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
